// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the multicycle controller's MEMORY state. It services load/store
//   strobes against a word-addressed on-chip RAM, inserts LATENCY wait cycles, and signals
//   completion with a one-cycle mem_ready pulse. Requests that are misaligned, out of range or
//   that assert both strobes are rejected without touching the RAM and flagged with addr_err.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   mem_read   in   load strobe, sampled in IDLE only
//   mem_write  in   store strobe, sampled in IDLE only
//   addr       in   byte address (ALU result)
//   wdata      in   store data (rt value)
//   rdata      out  load data, held until the next completed load
//   mem_ready  out  one-cycle completion pulse for every accepted request
//   mem_busy   out  high in WAIT, ACCESS and RESP
//   addr_err   out  qualifies mem_ready: request was rejected, no access performed
module data_mem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              addr_err
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 0..15");
  end
  if (ADDR_W < IDX_W + 2) begin : g_bad_addr_w
    $error("ADDR_W too narrow for DEPTH");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;      // only the word index of the latched address is needed later
  logic [DATA_W-1:0] wdata_q;
  logic              is_write_q;

  logic [DATA_W-1:0] ram [DEPTH];

  // Request decode, evaluated against the live inputs in IDLE.
  logic              req;
  logic              both_ops;
  logic              misaligned;
  logic              out_of_range;
  logic              req_bad;
  logic [ADDR_W-1:0] word_addr;

  always_comb begin
    req          = mem_read | mem_write;
    both_ops     = mem_read & mem_write;
    misaligned   = addr[1:0] != 2'b00;
    word_addr    = addr >> 2;
    // Full-width compare so upper address bits cannot alias into the RAM.
    out_of_range = word_addr >= ADDR_W'(DEPTH);
    req_bad      = both_ops | misaligned | out_of_range;
  end

  // Control FSM with registered outputs. mem_ready/addr_err are set on the edge entering RESP so
  // they are high exactly for the RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata      <= '0;
      mem_ready  <= 1'b0;
      mem_busy   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q      <= addr[IDX_W+1:2];
            wdata_q    <= wdata;
            is_write_q <= mem_write;
            mem_busy   <= 1'b1;
            if (req_bad) begin
              state_q   <= StResp;
              mem_ready <= 1'b1;
              addr_err  <= 1'b1;
            end else if (LATENCY == 0) begin
              state_q <= StAccess;
            end else begin
              state_q <= StWait;
              cnt_q   <= LAT_CNT;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!is_write_q) begin
            rdata <= ram[idx_q];
          end
          state_q   <= StResp;
          mem_ready <= 1'b1;
        end
        StResp: begin
          state_q  <= StIdle;
          mem_busy <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // RAM is never cleared. The reset term keeps a store from committing on an edge that coincides
  // with reset being asserted.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StAccess && is_write_q) begin
      ram[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Instance u_l2 uses LATENCY=2, u_l0 uses LATENCY=0,
//   both with DEPTH=256. Strobes are steered to one instance by sel; outputs are observed through
//   a matching mux.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        sel;        // 0: u_l2, 1: u_l0
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b;

  logic [31:0] o_rdata;
  logic        o_ready, o_busy, o_err;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(
    .DATA_W (32),
    .ADDR_W (32),
    .DEPTH  (256),
    .LATENCY(2)
  ) u_l2 (
    .clk      (clk),
    .reset    (reset),
    .mem_read (mem_read & ~sel),
    .mem_write(mem_write & ~sel),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata_a),
    .mem_ready(ready_a),
    .mem_busy (busy_a),
    .addr_err (err_a)
  );

  data_mem_responder #(
    .DATA_W (32),
    .ADDR_W (32),
    .DEPTH  (256),
    .LATENCY(0)
  ) u_l0 (
    .clk      (clk),
    .reset    (reset),
    .mem_read (mem_read & sel),
    .mem_write(mem_write & sel),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata_b),
    .mem_ready(ready_b),
    .mem_busy (busy_b),
    .addr_err (err_b)
  );

  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_ready = sel ? ready_b : ready_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_err   = sel ? err_b   : err_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request: strobe for one cycle, scramble the inputs right after acceptance, measure the
  // response delay in cycles and check the response fields.
  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int exp_n, input logic exp_err,
                        input logic [31:0] exp_rdata);
    int n;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = $urandom;
    wdata     = $urandom;
    check_eq({tag, "/busy"}, {31'd0, o_busy}, 32'd1);
    n = 1;
    while (!o_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "/lat"}, n, exp_n);
    check_eq({tag, "/err"}, {31'd0, o_err}, {31'd0, exp_err});
    check_eq({tag, "/rdata"}, o_rdata, exp_rdata);
    @(negedge clk);
    check_eq({tag, "/ready_off"}, {31'd0, o_ready}, 32'd0);
    check_eq({tag, "/busy_off"}, {31'd0, o_busy}, 32'd0);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [15:0] v;
    v = 16'(i) ^ 16'h5A00;
    return {v, ~v};
  endfunction

  initial begin
    int pulses;
    bit rd_done;

    reset     = 1'b1;
    sel       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    #1;
    check_eq("reset/l2", {rdata_a[27:0], ready_a, busy_a, err_a, 1'b0}, 32'd0);
    check_eq("reset/l0", {rdata_b[27:0], ready_b, busy_b, err_b, 1'b0}, 32'd0);
    check_eq("reset/rdata_hi", {rdata_a[31:28], rdata_b[31:28], 24'd0}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Store then load, LATENCY=2; a store leaves rdata at its reset value.
    do_req("t1_wr", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4, 1'b0, 32'h0);
    do_req("t1_rd", 1'b1, 1'b0, 32'h10, 32'h0, 4, 1'b0, 32'hDEAD_BEEF);

    // Misaligned load is rejected one cycle after sampling; rdata is kept.
    do_req("t2_mis", 1'b1, 1'b0, 32'h13, 32'h0, 1, 1'b1, 32'hDEAD_BEEF);

    // Out-of-range stores leave word 0 untouched, including one that only differs in upper bits.
    do_req("t3_wr0", 1'b0, 1'b1, 32'h0, 32'h1111_1111, 4, 1'b0, 32'hDEAD_BEEF);
    do_req("t3_rd0", 1'b1, 1'b0, 32'h0, 32'h0, 4, 1'b0, 32'h1111_1111);
    do_req("t3_oor", 1'b0, 1'b1, 32'h400, 32'h2222_2222, 1, 1'b1, 32'h1111_1111);
    do_req("t3_hi", 1'b0, 1'b1, 32'h1000_0000, 32'h3333_3333, 1, 1'b1, 32'h1111_1111);
    do_req("t3_chk", 1'b1, 1'b0, 32'h0, 32'h0, 4, 1'b0, 32'h1111_1111);

    // Both strobes together: rejected, no write.
    do_req("t4_both", 1'b1, 1'b1, 32'h0, 32'h4444_4444, 1, 1'b1, 32'h1111_1111);
    do_req("t4_chk", 1'b1, 1'b0, 32'h0, 32'h0, 4, 1'b0, 32'h1111_1111);

    // Load strobes during WAIT and during RESP are dropped: one pulse, no rdata update.
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 32'h40;
    wdata     = 32'h5555_5555;
    @(negedge clk);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    addr      = 32'h10;
    @(negedge clk);
    mem_read  = 1'b0;
    pulses    = 0;
    rd_done   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_ready) begin
        pulses++;
        if (!rd_done) begin
          mem_read = 1'b1;
          addr     = 32'h10;
          rd_done  = 1'b1;
        end
      end else begin
        mem_read = 1'b0;
      end
    end
    check_eq("t4_pulses", pulses, 1);
    check_eq("t4_no_load", o_rdata, 32'h1111_1111);
    do_req("t4_rd40", 1'b1, 1'b0, 32'h40, 32'h0, 4, 1'b0, 32'h5555_5555);

    // Reset during WAIT aborts a store before its commit edge.
    do_req("t5_wr", 1'b0, 1'b1, 32'h20, 32'hCAFE_0020, 4, 1'b0, 32'h5555_5555);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 32'h20;
    wdata     = 32'h0000_1234;
    @(negedge clk);
    mem_write = 1'b0;
    check_eq("t5_in_wait", {31'd0, o_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5_rst_out", {o_rdata[28:0], o_ready, o_busy, o_err}, 32'd0);
    check_eq("t5_rst_rdata_hi", {29'd0, o_rdata[31:29]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_idle", {30'd0, o_busy, o_ready}, 32'd0);
    do_req("t5_rd", 1'b1, 1'b0, 32'h20, 32'h0, 4, 1'b0, 32'hCAFE_0020);

    // LATENCY=0 instance: write/read back-to-back over every word, then a full read-back pass.
    sel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      do_req("t6_wr", 1'b0, 1'b1, 32'(i * 4), pat(i), 2, 1'b0, (i == 0) ? 32'h0 : pat(i - 1));
      do_req("t6_rd", 1'b1, 1'b0, 32'(i * 4), 32'h0, 2, 1'b0, pat(i));
    end
    for (int i = 0; i < 256; i++) begin
      do_req("t6_pass2", 1'b1, 1'b0, 32'(i * 4), 32'h0, 2, 1'b0, pat(i));
    end
    do_req("t6_oor", 1'b1, 1'b0, 32'h400, 32'h0, 1, 1'b1, pat(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
